// File: rtl/tnbuf_pkg.sv
// -----------------------------------------------------------------------------
// tnbuf_pkg
// Shared types and helpers for the multi-channel tristate bus arbiter.
//   state_t   : arbiter FSM states
//   rr_pick   : round-robin pick, returns a one-hot owner (or zero)
//   oh2idx    : one-hot to index conversion
//   tc_width  : width of the turnaround down-counter for a given TURN
// Helpers work on NCH_MAX-wide vectors so that any NCH up to NCH_MAX can
// share them without parameterised functions.
// -----------------------------------------------------------------------------
package tnbuf_pkg;

   localparam int NCH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   function automatic int tc_width(input int turn);
      return (turn > 0) ? $clog2(turn + 1) : 1;
   endfunction

   localparam int TC_W_DEF = tc_width(1);

   // Search upward from last+1, wrapping at nch; the last owner is
   // therefore considered last.
   function automatic logic [NCH_MAX-1:0] rr_pick(
      input logic [NCH_MAX-1:0] req,
      input int                 nch,
      input int                 last
   );
      logic [NCH_MAX-1:0] oh;
      logic               found;
      int                 idx;
      oh    = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NCH_MAX; k++) begin
         if (k <= nch && !found) begin
            idx = last + k;
            if (idx >= nch) idx = idx - nch;
            if (req[idx]) begin
               oh[idx] = 1'b1;
               found   = 1'b1;
            end
         end
      end
      return oh;
   endfunction

   function automatic int oh2idx(input logic [NCH_MAX-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < NCH_MAX; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/tnbuf_if.sv
// -----------------------------------------------------------------------------
// tnbuf_if
// Request/grant bundle between bus sources and the arbiter.
//   req     : per-channel level request
//   inp     : channel data, channel i at [i*WIDTH +: WIDTH]
//   gnt     : one-hot (or zero) registered grant
//   enb_out : bus drive enable, OR of gnt
//   busy    : arbiter is in DRIVE or TURN
// master = sources side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface tnbuf_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   logic [NCH-1:0]       req;
   logic [NCH*WIDTH-1:0] inp;
   logic [NCH-1:0]       gnt;
   logic                 enb_out;
   logic                 busy;

   modport master (output req, inp, input gnt, enb_out, busy);
   modport slave  (input req, inp, output gnt, enb_out, busy);
endinterface

// File: rtl/tnbuf_rr_arb.sv
// -----------------------------------------------------------------------------
// tnbuf_rr_arb
// Combinational round-robin picker.
//   req  : request vector
//   last : index of the previous owner (searched last)
//   pick : one-hot next owner, zero when nobody requests
//   vld  : some channel was picked
// -----------------------------------------------------------------------------
module tnbuf_rr_arb
   import tnbuf_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  last,
   output logic [NCH-1:0] pick,
   output logic           vld
);

   logic [NCH_MAX-1:0] pick_w;

   assign pick_w = rr_pick(NCH_MAX'(req), NCH, int'(last));
   assign pick   = pick_w[NCH-1:0];
   assign vld    = |pick_w;

endmodule

// File: rtl/tnbuf_bus_arb.sv
// -----------------------------------------------------------------------------
// tnbuf_bus_arb
// NCH sources share one WIDTH-bit tristate bus. A registered round-robin
// arbiter grants one owner at a time, inserts TURN released cycles between
// owners and forces rotation after HOLD_MAX cycles if someone else waits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, releases the bus immediately
//   bus   : req/inp in, gnt/enb_out/busy out (tnbuf_if.slave)
//   z     : tristate bus, inp[owner] while enb_out, else high-Z
// z stays a plain net outside the interface so it can be tied straight to
// the pad-side tristate cells.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | bus released, no owner
// ST_DRIVE | one owner holds the bus, hold_q counts cycles
// ST_TURN  | bus released, turn_q counts down turnaround
// -----------------------------------------------------------------------------
module tnbuf_bus_arb
   import tnbuf_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NCH      = 4,
   parameter int TURN     = 1,
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   tnbuf_if.slave           bus,
   output wire  [WIDTH-1:0] z
);

   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int HW  = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam int TCW = tc_width(TURN);

   state_t           state_q, state_nxt;
   logic [NCH-1:0]   gnt_q, gnt_nxt;
   logic [IW-1:0]    last_q, last_nxt;
   logic [HW-1:0]    hold_q, hold_nxt;
   logic [TCW-1:0]   turn_q, turn_nxt;

   logic [NCH-1:0]   pick;
   logic             pick_vld;
   logic [IW-1:0]    pick_idx;
   logic             own_req;
   logic             oth_req;
   logic             hold_tc;
   logic [WIDTH-1:0] z_mux;

   tnbuf_rr_arb #(.NCH(NCH), .IW(IW)) u_rr (
      .req  (bus.req),
      .last (last_q),
      .pick (pick),
      .vld  (pick_vld)
   );

   assign pick_idx = IW'(oh2idx(NCH_MAX'(pick)));
   assign own_req  = |(bus.req & gnt_q);
   assign oth_req  = |(bus.req & ~gnt_q);
   assign hold_tc  = (hold_q == HW'(HOLD_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         last_q  <= IW'(NCH - 1);
         hold_q  <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_nxt;
         gnt_q   <= gnt_nxt;
         last_q  <= last_nxt;
         hold_q  <= hold_nxt;
         turn_q  <= turn_nxt;
      end
   end

   // last_q is written with the owner at grant time, so a forced rotation
   // already deprioritises the outgoing owner without a separate update.
   always_comb begin
      state_nxt = state_q;
      gnt_nxt   = gnt_q;
      last_nxt  = last_q;
      hold_nxt  = hold_q;
      turn_nxt  = turn_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_nxt = ST_DRIVE;
               gnt_nxt   = pick;
               last_nxt  = pick_idx;
               hold_nxt  = '0;
            end
         end
         ST_DRIVE: begin
            if (!own_req || (hold_tc && oth_req)) begin
               if (TURN > 0) begin
                  state_nxt = ST_TURN;
                  gnt_nxt   = '0;
                  turn_nxt  = TCW'(TURN - 1);
               end else if (pick_vld) begin
                  gnt_nxt  = pick;
                  last_nxt = pick_idx;
                  hold_nxt = '0;
               end else begin
                  state_nxt = ST_IDLE;
                  gnt_nxt   = '0;
               end
            end else if (!hold_tc) begin
               hold_nxt = hold_q + HW'(1);
            end
         end
         ST_TURN: begin
            if (turn_q == '0) begin
               if (pick_vld) begin
                  state_nxt = ST_DRIVE;
                  gnt_nxt   = pick;
                  last_nxt  = pick_idx;
                  hold_nxt  = '0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               turn_nxt = turn_q - TCW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      z_mux = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt_q[i]) z_mux = z_mux | bus.inp[i*WIDTH +: WIDTH];
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.enb_out = |gnt_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign z           = bus.enb_out ? z_mux : {WIDTH{1'bz}};

endmodule
